memory_cycle: RTL
=================

# memory_cycle

Fourth pipeline stage (MEM) of the 5-stage RV32I core. It takes the EX/MEM bundle, performs byte/halfword/word loads and stores against an internal word-organised data memory, and registers the MEM/WB bundle that the writeback stage selects from. It also drives the MEM-stage forwarding taps used by the hazard unit.

## Interface
- DEPTH_WORDS, 1024: data memory depth in 32-bit words (power of two)
- ADDR_BITS, 10: log2(DEPTH_WORDS); word index = ALU_ResultM[ADDR_BITS+1:2]
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 clears MEM/WB registers immediately)
- RegWriteM  input  1  register-file write enable from EX/MEM
- MemWriteM  input  1  store enable
- ResultSrcM  input  2  result select (00 ALU, 01 load, 10 PC+4)
- funct3M  input  3  access type: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- RD_M  input  5  destination register
- ALU_ResultM  input  32  effective address / ALU result
- WriteDataM  input  32  store data (rs2)
- PCPlus4M  input  32  PC+4
- RegWriteW  output  1  registered
- ResultSrcW  output  2  registered
- RD_W  output  5  registered
- ALU_ResultW  output  32  registered
- ReadDataW  output  32  registered, extended load data
- PCPlus4W  output  32  registered
- MisalignW  output  1  registered, access in this slot was misaligned
- ALU_ResultM_fwd  output  32  combinational copy of ALU_ResultM (forwarding tap)

## Operation
- Memory: DEPTH_WORDS x 32, 4 byte lanes; combinational read, synchronous byte-enabled write; contents not reset.
- Word index wraps: address bits above ADDR_BITS+1 ignored.
- Byte offset off = ALU_ResultM[1:0]. Misaligned: halfword with off[0]=1, word with off!=0. Byte never misaligned. Misalign evaluated only for loads (ResultSrcM=01) or stores (MemWriteM=1); else 0.
- Store: sb writes lane off with WriteDataM[7:0]; sh writes lanes off,off+1 with WriteDataM[15:0]; sw writes all lanes. Misaligned store: no lanes written. funct3M not in {000,001,010} with MemWriteM=1: no write, not flagged.
- Load extraction from read word: lb sign-extends byte at lane off; lbu zero-extends; lh/lhu sign/zero-extend halfword at lanes off,off+1; lw whole word. Misaligned or unsupported funct3 load: ReadData = 0.
- Misaligned access: RegWriteW forced 0 for that slot, MisalignW=1; all other fields pass through.
- Non-memory instructions: ReadDataW takes the extracted value anyway (don't-care to writeback), ALU_ResultW/PCPlus4W pass through.

## Timing
- Reset (rst=0, async): RegWriteW=0, ResultSrcW=00, RD_W=0, ALU_ResultW=0, ReadDataW=0, PCPlus4W=0, MisalignW=0. Memory writes suppressed while rst=0. Release synchronous to next rising edge; first edge after release captures inputs.
- Latency: 1 cycle EX/MEM -> MEM/WB for every field.
- Store commits at the rising edge ending its MEM cycle; a load to the same word in the following cycle returns the new data (no bypass needed, read is combinational on updated array).
- Reset asserted mid-store: the edge coincident with rst=0 writes nothing.
- No stall/flush inputs; bubbles arrive as RegWriteM=0, MemWriteM=0.

## Test plan
- Reset: drive all inputs nonzero, pulse rst=0 between edges -> every W output 0 immediately, memory unchanged.
- sw 0xDEADBEEF @0x10, then lw @0x10 (RD_M=5) -> next cycle ReadDataW=0xDEADBEEF, RegWriteW=1, RD_W=5, MisalignW=0.
- sb 0x80 @0x13 onto word 0x11223344 -> word becomes 0x80223344; lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080.
- sh 0xBEEF @0x22 onto 0 -> word 0xBEEF0000; lh @0x22 -> 0xFFFFBEEF; lhu @0x22 -> 0x0000BEEF.
- Misaligned: lw @0x11 with RegWriteM=1 -> RegWriteW=0, MisalignW=1, ReadDataW=0; sh @0x21 -> word @0x20 unchanged, MisalignW=1.
- Wrap: sw 0xCAFEF00D @ (DEPTH_WORDS*4 + 0x8), lw @0x8 -> 0xCAFEF00D; ALU op (ResultSrcM=00, ALU_ResultM=0x1234) -> ALU_ResultW=0x1234 one cycle later.

Source files
------------

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the RV32I pipeline (data memory access + MEM/WB register)
//   in : clk, rst (async active-low), EX/MEM bundle (RegWriteM, MemWriteM, ResultSrcM,
//        funct3M, RD_M, ALU_ResultM, WriteDataM, PCPlus4M)
//   out: MEM/WB bundle (RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W,
//        MisalignW) and the ALU_ResultM_fwd forwarding tap
module memory_cycle #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW,
  output logic [31:0] ALU_ResultM_fwd
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [ADDR_BITS-1:0] idx;
  logic [1:0] off;
  logic mem_acc, misal;
  logic [3:0] be;
  logic [31:0] wdata, rword, sh_word, ld;
  logic unused_addr;
  logic reg_write_d, reg_write_q, misalign_d, misalign_q;
  logic [1:0] result_src_d, result_src_q;
  logic [4:0] rd_d, rd_q;
  logic [31:0] alu_result_d, alu_result_q, read_data_d, read_data_q, pc_plus4_d, pc_plus4_q;

  assign unused_addr = ^ALU_ResultM[31:ADDR_BITS+2];
  assign ALU_ResultM_fwd = ALU_ResultM;

  always_comb begin
    idx = ALU_ResultM[ADDR_BITS+1:2];
    off = ALU_ResultM[1:0];
    mem_acc = (ResultSrcM == 2'b01) || MemWriteM;
    misal = mem_acc && ((funct3M[1:0] == 2'b01 && off[0]) || (funct3M == 3'b010 && off != 2'b00));
    be = (!MemWriteM || misal)  ? 4'b0000 :
         (funct3M == 3'b000)    ? 4'b0001 << off :
         (funct3M == 3'b001)    ? 4'b0011 << off :
         (funct3M == 3'b010)    ? 4'b1111 : 4'b0000;
    // replicate store data across lanes so each enabled lane sees the right bits
    wdata = (funct3M[1:0] == 2'b00) ? {4{WriteDataM[7:0]}} :
            (funct3M[1:0] == 2'b01) ? {2{WriteDataM[15:0]}} : WriteDataM;
    rword = mem[idx];
    sh_word = rword >> {off, 3'b000};
    ld = misal                ? 32'd0 :
         (funct3M == 3'b000)  ? {{24{sh_word[7]}}, sh_word[7:0]} :
         (funct3M == 3'b001)  ? {{16{sh_word[15]}}, sh_word[15:0]} :
         (funct3M == 3'b010)  ? rword :
         (funct3M == 3'b100)  ? {24'd0, sh_word[7:0]} :
         (funct3M == 3'b101)  ? {16'd0, sh_word[15:0]} : 32'd0;
    reg_write_d  = RegWriteM && !misal;
    result_src_d = ResultSrcM;
    rd_d         = RD_M;
    alu_result_d = ALU_ResultM;
    read_data_d  = ld;
    pc_plus4_d   = PCPlus4M;
    misalign_d   = misal;
  end

  // gated by rst so an edge coinciding with reset writes nothing
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      alu_result_q <= 32'd0;
      read_data_q  <= 32'd0;
      pc_plus4_q   <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      misalign_q   <= misalign_d;
    end
  end

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign RD_W        = rd_q;
  assign ALU_ResultW = alu_result_q;
  assign ReadDataW   = read_data_q;
  assign PCPlus4W    = pc_plus4_q;
  assign MisalignW   = misalign_q;
endmodule
